// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM with one-cycle registered read.
// Write bursts stream straight to the RAM; read bursts return through a 2-entry FIFO.
module ram_burst_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_cs,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_cnt_reg;
    logic [ADDR_W-1:0]   rem_reg;        // handshakes (write) or pops (read) left, minus one
    logic [ADDR_W:0]     issue_left_reg; // read words not yet issued to the RAM
    logic                in_flight_reg;
    logic [DATA_W-1:0]   fifo_reg [2];
    logic                wr_ptr_reg, rd_ptr_reg;
    logic [1:0]          count_reg;
    logic                done_reg;

    logic accept, w_hs, pop, issue, last;

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign wready    = (state_reg == WRITE);
    assign w_hs      = wready && wvalid;
    assign rvalid    = (count_reg != 2'd0);
    assign rdata     = fifo_reg[rd_ptr_reg];
    assign pop       = rvalid && rready;
    assign last      = (rem_reg == '0);
    assign done      = done_reg;

    // A word popped this cycle frees its slot at the same edge, which is what
    // allows one issue per cycle while the consumer keeps up.
    assign issue = (state_reg == READ) && (issue_left_reg != '0) &&
                   (({1'b0, count_reg} + {2'b00, in_flight_reg}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_next = state_reg;
        mem_addr   = '0;
        mem_data   = '0;
        mem_cs     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept)
                    state_next = cmd_wr ? WRITE : READ;
            end
            WRITE: begin
                mem_addr = addr_cnt_reg;
                mem_data = wdata;
                mem_cs   = wvalid;
                mem_wr   = wvalid;
                if (w_hs && last)
                    state_next = IDLE;
            end
            READ: begin
                mem_addr = addr_cnt_reg;
                mem_cs   = issue;
                mem_rd   = issue;
                if (pop && last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_cnt_reg   <= '0;
            rem_reg        <= '0;
            issue_left_reg <= '0;
            in_flight_reg  <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_flight_reg <= issue;
            done_reg      <= (w_hs && last) || ((state_reg == READ) && pop && last);
            if (accept) begin
                addr_cnt_reg   <= cmd_addr;
                rem_reg        <= cmd_len;
                issue_left_reg <= {1'b0, cmd_len} + (ADDR_W+1)'(1);
            end else if (w_hs) begin
                addr_cnt_reg <= addr_cnt_reg + ADDR_W'(1);
                rem_reg      <= rem_reg - ADDR_W'(1);
            end else if (state_reg == READ) begin
                if (issue) begin
                    addr_cnt_reg   <= addr_cnt_reg + ADDR_W'(1);
                    issue_left_reg <= issue_left_reg - (ADDR_W+1)'(1);
                end
                if (pop)
                    rem_reg <= rem_reg - ADDR_W'(1);
            end
        end
    end

    // Return FIFO: the RAM's registered output is captured one cycle after each issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++)
                fifo_reg[i] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (in_flight_reg) begin
                fifo_reg[wr_ptr_reg] <= mem_dout;
                wr_ptr_reg           <= !wr_ptr_reg;
            end
            if (pop)
                rd_ptr_reg <= !rd_ptr_reg;
            count_reg <= count_reg + {1'b0, in_flight_reg} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: behavioural RAM, reference memory image and
// latency/credit model of the read return path, directed plus random bursts.
module tb_ram_burst_master;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic [DW-1:0] wdata;
    logic          wvalid, wready;
    logic [DW-1:0] rdata;
    logic          rvalid, rready;
    logic          busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_cs, mem_rd, mem_wr;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wq [$];

    int checks = 0;
    int errors = 0;

    ram_burst_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dout(mem_dout)
    );

    always #5 clk = !clk;

    // 1Kx8 synchronous RAM with registered read data
    always @(posedge clk) begin
        if (mem_cs && mem_wr) ram[mem_addr] <= mem_data;
        if (mem_cs && mem_rd) mem_dout <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("rd_wr_exclusive", {31'd0, mem_rd && mem_wr}, 0);
            chk("cs_while_idle", {31'd0, cmd_ready && mem_cs}, 0);
        end
    end

    task automatic accept_cmd(input bit wr, input int addr, input int len);
        int t;
        t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = AW'(addr); cmd_len = AW'(len);
        #1;
        while (!cmd_ready && t < 100) begin
            @(negedge clk); #1; t++;
        end
        chk("accept_ready", {31'd0, cmd_ready}, 1);
    endtask

    // mode: 0 = wvalid held, 1 = pattern 1,0,1,1,0,1, 2 = random
    task automatic do_write(input int addr, input int len, input int mode,
                            input bit chain, input int naddr, input int nlen);
        int k, n;
        int pat[6];
        pat = '{1, 0, 1, 1, 0, 1};
        accept_cmd(1'b1, addr, len);
        k = 0; n = 0;
        while (k <= len && n < 4000) begin
            @(negedge clk);
            if (chain) begin
                cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = AW'(naddr); cmd_len = AW'(nlen);
            end else cmd_valid = 1'b0;
            wvalid = (mode == 0) ? 1'b1 : (mode == 1) ? pat[n % 6][0] : 1'($urandom_range(0, 1));
            wdata  = (k < wq.size()) ? wq[k] : DW'($urandom);
            #1;
            chk("w_cmd_ready_low", {31'd0, cmd_ready}, 0);
            chk("w_busy", {31'd0, busy}, 1);
            chk("w_done_early", {31'd0, done}, 0);
            chk("w_wready", {31'd0, wready}, 1);
            chk("w_mem_wr", {31'd0, mem_wr}, {31'd0, wvalid});
            chk("w_mem_cs", {31'd0, mem_cs}, {31'd0, wvalid});
            if (wvalid) begin
                chk("w_addr", {22'd0, mem_addr}, (addr + k) % DEPTH);
                chk("w_data", {24'd0, mem_data}, {24'd0, wdata});
                ref_mem[(addr + k) % DEPTH] = wdata;
                k++;
            end
            n++;
        end
        if (n >= 4000) chk("w_timeout", 1, 0);
        if (mode == 0) chk("w_consecutive", n, len + 1);
        @(negedge clk);
        wvalid = 1'b0;
        #1;
        chk("w_done", {31'd0, done}, 1);
        chk("w_ready_at_done", {31'd0, cmd_ready}, 1);
    endtask

    // mode: 0 = rready held, 1 = pattern 1,0,0,1, 2 = random
    task automatic do_read(input int addr, input int len, input int mode,
                           input bit skip_accept, input bit tamper, input int abort_after);
        logic [DW-1:0] expq [$];
        int issue_n [$];
        int issued, popped, n, outst;
        bit pop, exp_issue, exp_rvalid;
        int pat[4];
        pat = '{1, 0, 0, 1};
        for (int i = 0; i <= len; i++) expq.push_back(ref_mem[(addr + i) % DEPTH]);
        if (!skip_accept) accept_cmd(1'b0, addr, len);
        issued = 0; popped = 0; n = 0;
        while (popped <= len && n < 4000) begin
            if (abort_after > 0 && popped == abort_after) break;
            @(negedge clk);
            if (tamper && n < 4) begin
                cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = AW'((addr + 300) % DEPTH); cmd_len = AW'(5);
            end else cmd_valid = 1'b0;
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[n % 4][0] : 1'($urandom_range(0, 1));
            #1;
            chk("r_cmd_ready_low", {31'd0, cmd_ready}, 0);
            chk("r_done_early", {31'd0, done}, 0);
            chk("r_wready", {31'd0, wready}, 0);
            chk("r_mem_wr", {31'd0, mem_wr}, 0);
            // a word issued in sample n is visible two samples later
            exp_rvalid = (popped < issued) && (issue_n[popped] + 2 <= n);
            chk("r_rvalid", {31'd0, rvalid}, {31'd0, exp_rvalid});
            pop = rvalid && rready;
            if (rvalid && popped <= len)
                chk("r_rdata", {24'd0, rdata}, {24'd0, expq[popped]});
            outst = issued - popped;
            exp_issue = (issued <= len) && (outst - int'(pop) < 2);
            chk("r_mem_rd", {31'd0, mem_rd}, {31'd0, exp_issue});
            chk("r_mem_cs", {31'd0, mem_cs}, {31'd0, exp_issue});
            if (mem_rd) begin
                chk("r_addr", {22'd0, mem_addr}, (addr + issued) % DEPTH);
                issue_n.push_back(n);
                issued++;
            end
            if (pop) popped++;
            n++;
        end
        if (n >= 4000) chk("r_timeout", 1, 0);
        if (abort_after > 0) return;
        if (mode == 0) chk("r_cycles", n, len + 3);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("r_done", {31'd0, done}, 1);
        chk("r_ready_at_done", {31'd0, cmd_ready}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, l;
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata = '0; wvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = DW'($urandom);
            ref_mem[i] = ram[i];
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rvalid", {31'd0, rvalid}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_mem_cs", {31'd0, mem_cs}, 0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 0);
        chk("rst_mem_data", {24'd0, mem_data}, 0);
        chk("rst_wready", {31'd0, wready}, 0);
        @(negedge clk);
        rst = 1'b0;

        wq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_write(10'h010, 3, 0, 1'b0, 0, 0);
        do_read(10'h010, 3, 0, 1'b0, 1'b0, 0);

        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(DW'($urandom));
        do_write(10'h3FE, 3, 0, 1'b0, 0, 0);
        do_read(10'h3FE, 3, 0, 1'b0, 1'b0, 0);

        do_read(10'h3FC, 7, 1, 1'b0, 1'b0, 0);

        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(DW'($urandom));
        do_write(10'h200, 3, 1, 1'b0, 0, 0);
        do_read(10'h200, 3, 2, 1'b0, 1'b0, 0);

        // abort a 16-word read after 5 pops
        do_read(10'h100, 15, 0, 1'b0, 1'b0, 5);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_rvalid", {31'd0, rvalid}, 0);
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_mem_cs", {31'd0, mem_cs}, 0);
        chk("abort_mem_rd", {31'd0, mem_rd}, 0);
        chk("abort_mem_addr", {22'd0, mem_addr}, 0);
        chk("abort_mem_data", {24'd0, mem_data}, 0);
        chk("abort_cmd_ready", {31'd0, cmd_ready}, 1);
        @(negedge clk);
        #1;
        chk("abort_no_done", {31'd0, done}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        rst = 1'b0;

        // command held through done is taken in the done cycle; busy-time changes ignored
        wq.delete();
        for (int i = 0; i < 6; i++) wq.push_back(DW'($urandom));
        do_write(10'h050, 5, 2, 1'b1, 10'h04E, 9);
        do_read(10'h04E, 9, 0, 1'b1, 1'b1, 0);

        for (int r = 0; r < 8; r++) begin
            a = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                for (int i = 0; i <= l; i++) wq.push_back(DW'($urandom));
                do_write(a, l, 2, 1'b0, 0, 0);
            end else begin
                do_read(a, l, 2, 1'b0, 1'b0, 0);
            end
        end
        do_read(10'h3F0, 31, 2, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
